// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter, the fetch stage and the loader.
// Holds the arbiter state encoding, the memory geometry and an address range helper.
package imem_arbiter_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/imem_arbiter_pick.sv
// Combinational grant selection for the instruction-memory arbiter.
// Fetch has priority unless the loader has been starved or holds the lock.
module imem_arb_pick
    import imem_arbiter_pkg::*;
#(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  arb_state_e       state_i,
    input  logic             f_req_i,
    input  logic             l_req_i,
    input  logic             l_lock_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             f_gnt_o,
    output logic             l_gnt_o,
    output arb_state_e       state_d_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic       starved_s;
    arb_state_e load_next_s;

    assign starved_s   = (starve_cnt_i == LIMIT_C);
    assign load_next_s = l_lock_i ? LOCKED : LOAD;

    // Winner selection and the state that follows it
    always_comb begin
        f_gnt_o   = 1'b0;
        l_gnt_o   = 1'b0;
        state_d_o = IDLE;
        if (state_i == LOCKED) begin
            if (l_req_i) begin
                l_gnt_o   = 1'b1;
                state_d_o = load_next_s;
            end else if (l_lock_i) begin
                state_d_o = LOCKED;
            end else begin
                state_d_o = IDLE;
            end
        end else if (f_req_i && !(l_req_i && starved_s)) begin
            f_gnt_o   = 1'b1;
            state_d_o = FETCH;
        end else if (l_req_i) begin
            l_gnt_o   = 1'b1;
            state_d_o = load_next_s;
        end else begin
            state_d_o = IDLE;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-port instruction memory between fetch (read-only)
// and the loader/debug port (read/write), with starvation guard and loader lock.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int DEPTH        = IMEM_DEPTH,
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_readData
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [31:0]      addr_hold_q;
    logic             f_rvalid_q, l_rvalid_q, l_err_q;
    logic [31:0]      f_rdata_q, l_rdata_q;

    logic             pick_f_gnt_s, pick_l_gnt_s;
    logic             any_gnt_s, in_range_s, l_read_s;
    logic [31:0]      win_addr_s, rdata_s;

    imem_arb_pick #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .state_i      (state_q),
        .f_req_i      (f_req),
        .l_req_i      (l_req),
        .l_lock_i     (l_lock),
        .starve_cnt_i (starve_q),
        .f_gnt_o      (pick_f_gnt_s),
        .l_gnt_o      (pick_l_gnt_s),
        .state_d_o    (state_d)
    );

    // Reset forces every grant, and therefore every memory strobe, low at once
    assign f_gnt      = pick_f_gnt_s & ~reset;
    assign l_gnt      = pick_l_gnt_s & ~reset;
    assign any_gnt_s  = f_gnt | l_gnt;
    assign l_read_s   = l_gnt & ~l_we;
    assign win_addr_s = f_gnt ? 32'(f_addr) : 32'(l_addr);
    assign in_range_s = addr_in_range(win_addr_s, DEPTH);
    assign rdata_s    = in_range_s ? mem_readData : 32'h0000_0000;

    assign mem_address   = any_gnt_s ? win_addr_s : addr_hold_q;
    assign mem_writeData = l_wdata;
    assign mem_memWrite  = l_gnt & l_we & in_range_s;
    assign mem_memRead   = f_gnt | l_read_s;

    assign f_rvalid = f_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign l_rvalid = l_rvalid_q;
    assign l_rdata  = l_rdata_q;
    assign l_err    = l_err_q;

    // Starvation count saturates at the limit and clears when the loader wins or goes idle
    always_comb begin
        starve_d = '0;
        if (l_req && !l_gnt) begin
            if (starve_q == LIMIT_C) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            starve_d = '0;
        end
    end

    // Arbiter state, starvation counter and registered read responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            addr_hold_q <= 32'h0000_0000;
            f_rvalid_q  <= 1'b0;
            f_rdata_q   <= 32'h0000_0000;
            l_rvalid_q  <= 1'b0;
            l_rdata_q   <= 32'h0000_0000;
            l_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_hold_q <= mem_address;
            f_rvalid_q  <= f_gnt;
            l_rvalid_q  <= l_read_s;
            l_err_q     <= l_gnt & ~in_range_s;
            if (f_gnt) begin
                f_rdata_q <= rdata_s;
            end
            if (l_read_s) begin
                l_rdata_q <= rdata_s;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed steps push expected responses,
// a negedge monitor pops and compares whenever a response appears.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, l_req, l_we, l_lock;
    logic [6:0]  f_addr, l_addr;
    logic [31:0] l_wdata;
    logic        f_gnt, f_rvalid, l_gnt, l_rvalid, l_err;
    logic [31:0] f_rdata, l_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        err;
    } l_exp_t;

    logic [31:0] f_q[$];
    l_exp_t      l_q[$];
    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(64), .ADDR_W(7), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
    );

    // Instruction memory: combinational read, write commits on the negedge
    assign mem_readData = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'hFFFF_FFFF;
    always @(negedge clk) begin
        if (mem_memWrite && mem_address < 32'd64) mem[mem_address[5:0]] <= mem_writeData;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic fr, input logic [6:0] fa, input logic lr, input logic lw,
                        input logic lk, input logic [6:0] la, input logic [31:0] wd,
                        input logic efg, input logic elg, input string nm);
        @(posedge clk); #1;
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = wd;
        #1;
        chk({nm, ".f_gnt"}, 32'(f_gnt), 32'(efg));
        chk({nm, ".l_gnt"}, 32'(l_gnt), 32'(elg));
    endtask

    task automatic idle(input string nm);
        step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, nm);
    endtask

    task automatic push_l(input logic rv, input logic [31:0] rd, input logic err);
        l_exp_t e;
        e.rv = rv; e.rd = rd; e.err = err;
        l_q.push_back(e);
    endtask

    // Response monitor: every rvalid/err pulse must match the oldest expectation
    always @(negedge clk) begin
        l_exp_t le;
        if (!reset) begin
            if (f_rvalid) begin
                if (f_q.size() == 0) chk("f_unexpected_rvalid", 32'd1, 32'd0);
                else chk("f_rdata", f_rdata, f_q.pop_front());
            end
            if (l_rvalid || l_err) begin
                if (l_q.size() == 0) begin
                    chk("l_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    le = l_q.pop_front();
                    chk("l_rvalid", 32'(l_rvalid), 32'(le.rv));
                    chk("l_err", 32'(l_err), 32'(le.err));
                    if (le.rv) chk("l_rdata", l_rdata, le.rd);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3] = 32'hDEAD_BEEF;
        mem[5] = 32'h5555_5555;
        reset = 1'b1;
        f_req = 1'b0; f_addr = 7'd0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        l_addr = 7'd0; l_wdata = 32'h0;
        #2;
        chk("rst.f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst.l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst.l_err", 32'(l_err), 32'd0);
        chk("rst.f_rdata", f_rdata, 32'd0);
        chk("rst.l_rdata", l_rdata, 32'd0);
        chk("rst.memRead", 32'(mem_memRead), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Fetch only
        step(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, "fetch");
        f_q.push_back(32'hDEAD_BEEF);
        chk("fetch.memRead", 32'(mem_memRead), 32'd1);
        chk("fetch.mem_address", mem_address, 32'd3);
        idle("idle1");
        idle("idle2");
        chk("hold.f_rvalid", 32'(f_rvalid), 32'd0);
        chk("hold.f_rdata", f_rdata, 32'hDEAD_BEEF);

        // Loader write then fetch and loader read of the same word
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd10, 32'h1234_5678, 1'b0, 1'b1, "lwr10");
        chk("lwr10.memWrite", 32'(mem_memWrite), 32'd1);
        chk("lwr10.memRead", 32'(mem_memRead), 32'd0);
        step(1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, "frd10");
        f_q.push_back(32'h1234_5678);
        step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd10, 32'h0, 1'b0, 1'b1, "lrd10");
        push_l(1'b1, 32'h1234_5678, 1'b0);
        idle("idle3");

        // Contention: F,F,F,F,L repeating
        for (int i = 0; i < 10; i++) begin
            logic lw_i;
            lw_i = (i % 5 == 4);
            step(1'b1, 7'd3, 1'b1, 1'b0, 1'b0, 7'd10, 32'h0, ~lw_i, lw_i, $sformatf("cont%0d", i));
            if (lw_i) push_l(1'b1, 32'h1234_5678, 1'b0);
            else f_q.push_back(32'hDEAD_BEEF);
        end
        idle("idle4");

        // Lock burst: fetch shut out for all locked writes
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd20, 32'hA000_0000, 1'b0, 1'b1, "lock0");
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 7'd3, 1'b1, 1'b1, 1'b1, 7'(20 + i), 32'hA000_0000 + 32'(i),
                 1'b0, 1'b1, $sformatf("lock%0d", i));
        end
        step(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, "unlock");
        step(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, "after_unlock");
        f_q.push_back(32'hDEAD_BEEF);
        step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd28, 32'h0, 1'b0, 1'b1, "lrd28");
        push_l(1'b1, 32'hA000_0008, 1'b0);
        idle("idle5");

        // Out of range
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd63, 32'h6363_6363, 1'b0, 1'b1, "lwr63");
        chk("lwr63.memWrite", 32'(mem_memWrite), 32'd1);
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd64, 32'h6464_6464, 1'b0, 1'b1, "lwr64");
        chk("lwr64.memWrite", 32'(mem_memWrite), 32'd0);
        chk("lwr64.mem_address", mem_address, 32'd64);
        push_l(1'b0, 32'h0, 1'b1);
        step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd64, 32'h0, 1'b0, 1'b1, "lrd64");
        push_l(1'b1, 32'h0, 1'b1);
        step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd63, 32'h0, 1'b0, 1'b1, "lrd63");
        push_l(1'b1, 32'h6363_6363, 1'b0);
        step(1'b1, 7'd100, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, "frd100");
        f_q.push_back(32'h0);
        idle("idle6");
        chk("idle6.mem_address_hold", mem_address, 32'd100);
        chk("idle6.memRead", 32'(mem_memRead), 32'd0);

        // Async reset in the middle of a locked burst
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd6, 32'h6666_6666, 1'b0, 1'b1, "rlock0");
        step(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd5, 32'h7777_7777, 1'b0, 1'b1, "rlock1");
        #1;
        reset = 1'b1;
        #1;
        chk("arst.l_gnt", 32'(l_gnt), 32'd0);
        chk("arst.memWrite", 32'(mem_memWrite), 32'd0);
        chk("arst.memRead", 32'(mem_memRead), 32'd0);
        chk("arst.mem_address", mem_address, 32'd0);
        chk("arst.l_rdata", l_rdata, 32'd0);
        chk("arst.f_rdata", f_rdata, 32'd0);
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("arst.no_partial_write", mem[5], 32'h5555_5555);
        reset = 1'b0;
        step(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, "post_rst_fetch");
        f_q.push_back(32'hDEAD_BEEF);
        idle("idle7");
        idle("idle8");
        idle("idle9");

        chk("f_queue_drained", 32'(f_q.size()), 32'd0);
        chk("l_queue_drained", 32'(l_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port 64-word instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).
- Drives the memory's address, writeData, memWrite and memRead pins.
- Registers read data back to the winning requester and enforces starvation-free, lockable arbitration.
- Sits between the fetch stage and the instruction memory; the loader taps in from the boot/debug path.

Parameters:
- DEPTH, 64, number of words in the instruction memory; addresses are word indices.
- ADDR_W, 6, requester address width; must be ≥ clog2(DEPTH).
- STARVE_LIMIT, 4, consecutive cycles the loader may lose to fetch before it is forced a grant.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid (registered).
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_lock  in  1  loader holds ownership while asserted.
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader granted this cycle (combinational).
- l_rvalid  out  1  loader read data valid (registered).
- l_rdata  out  32  loader read data.
- l_err  out  1  out-of-range access, one-cycle pulse (registered).
- mem_address  out  32  to memory address, zero-extended.
- mem_writeData  out  32  to memory writeData.
- mem_memWrite  out  1  to memory memWrite.
- mem_memRead  out  1  to memory memRead.
- mem_readData  in  32  from memory readData (combinational).

Behaviour:
- Reset (async, immediate):
  - f_rvalid, l_rvalid, l_err = 0; f_rdata, l_rdata = 0.
  - Starvation counter = 0; state = IDLE.
  - mem_memWrite = 0, mem_memRead = 0 while reset is high.
- States:
  - IDLE: no owner.
  - FETCH: fetch granted this cycle.
  - LOAD: loader granted this cycle.
  - LOCKED: loader owns the memory exclusively.
- Grant decision (combinational, from current state and requests):
  - In LOCKED, only the loader can be granted; f_gnt = 0.
  - Otherwise, if only one requester is active, it wins.
  - If both are active, fetch wins unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
  - The next state is the winner's state; with no requests the next state is IDLE.
  - Entering LOAD with l_lock = 1 moves to LOCKED next cycle.
  - LOCKED exits to IDLE the first cycle l_lock = 0 and l_req = 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle l_req = 1 and l_gnt = 0.
  - Clears when l_gnt = 1 or l_req = 0.
- Memory drive during a grant cycle:
  - mem_address = winner address, zero-extended to 32 bits.
  - mem_memRead = 1 for reads.
  - mem_memWrite = 1 only for a loader write with l_addr < DEPTH. The memory commits on the negedge inside the grant cycle.
  - With no grant, mem_memWrite = 0, mem_memRead = 0, mem_address holds its last value.
- Read latency:
  - mem_readData is sampled at the posedge ending the grant cycle.
  - The matching rvalid is high for exactly one cycle, one cycle after the grant.
  - rdata holds its value until the next rvalid for that requester.
- Write response: loader writes produce no rvalid. They are complete at the end of the grant cycle, so a read of the same address in the next cycle returns the new data.
- Out of range (addr ≥ DEPTH):
  - The request is still granted, but no memory write is issued.
  - Reads return rdata = 0 with rvalid.
  - For loader accesses, l_err pulses with the response timing. Fetch out-of-range returns 0 silently.
- Requests are level-held until granted; address and data must be stable while req is high.
- Simultaneous lock release and fetch request: fetch can win in the cycle immediately after LOCKED exits.
- Reset mid-lock returns to IDLE. No partial write can occur, because memWrite is gated low by reset.

Decomposition:
- Shared package holds:
  - state enum {IDLE, FETCH, LOAD, LOCKED};
  - IMEM_DEPTH = 64 and IMEM_ADDR_W = 6, also used by the fetch stage and loader.
- Natural sub-module: imem_arb_pick, a combinational grant/priority + starvation comparator.
- The FSM, counter and response registers stay in the top module.

Test Plan:
- Fetch only: f_req = 1, f_addr = 3 on preloaded word 0xDEADBEEF → f_gnt the same cycle; f_rvalid = 1 and f_rdata = 0xDEADBEEF next cycle; l_* outputs silent.
- Loader write then fetch read: l_we = 1, l_addr = 10, l_wdata = 0x12345678 → memory written at the negedge. Then f_addr = 10 → f_rdata = 0x12345678.
- Contention and starvation: f_req and l_req held high continuously with STARVE_LIMIT = 4 → grants are F, F, F, F, L repeating, and starve_cnt returns to 0 after each L.
- Lock burst: l_lock = 1 with 8 back-to-back writes while f_req = 1 → f_gnt = 0 for all 8 cycles. Dropping l_lock and l_req → f_gnt on the next cycle.
- Out of range: loader write to addr 63 and to addr 64 (ADDR_W = 7 build) → the first writes; the second gives mem_memWrite = 0 and an l_err pulse. A loader read of 64 returns l_rdata = 0 with l_rvalid and l_err.
- Async reset asserted mid-LOCKED between clock edges → all outputs zero immediately, state IDLE. After reset is released, a fetch is granted on the first request.
